// File: rtl/rv_stream_gen.sv
// rv_stream_gen
//    Ready/valid burst transmitter. A one-cycle start pulse latches a burst
//    length, an inter-beat gap and a seed value. The block then emits
//    burst_len beats, honouring out_ready backpressure. It optionally inserts
//    gap_len idle cycles after every accepted beat except the last.
//
//    Optional feature macro: RV_GEN_LFSR_EN
//       defined   : beats advance as a 16-bit right-shift Galois LFSR
//                   (taps 0xB400). Requires DATA_W == 16. A zero seed loads as 0x0001.
//       undefined : beats advance by +1, wrapping all-ones to zero.
//
// Ports
//    clk        : clock, rising-edge
//    reset_n    : asynchronous active-low reset
//    start      : one-cycle pulse, samples burst_len / gap_len / seed when idle
//    burst_len  : beats in the burst (0 = empty burst, done pulse only)
//    gap_len    : idle cycles after each accepted non-final beat
//    seed       : value of the first beat
//    out_ready  : downstream ready
//    out_valid  : beat valid
//    data_out   : beat payload
//    out_last   : marks the final beat of the burst
//    busy       : burst in progress (SEND or GAP)
//    done       : one-cycle pulse when the burst completes
//    beat_count : accepted beats since reset, wraps

module rv_stream_gen #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 16,
   parameter int GAP_W  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic [GAP_W-1:0]  gap_len,
   input  logic [DATA_W-1:0] seed,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  beat_count
);

   typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

   state_t             state_reg, state_next;
   logic [DATA_W-1:0]  data_reg, data_next;
   logic [LEN_W-1:0]   remaining_reg, remaining_next;
   logic [GAP_W-1:0]   gap_len_reg, gap_len_next;
   logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
   logic [LEN_W-1:0]   beat_count_reg, beat_count_next;
   logic [DATA_W-1:0]  seed_load;

`ifdef RV_GEN_LFSR_EN
   localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(16'hB400);

   // An all-zero state would lock the LFSR, so a zero seed starts at 1.
   assign seed_load = (seed == '0) ? DATA_W'(1) : seed;

   function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] d);
      return (d >> 1) ^ (d[0] ? LFSR_TAPS : '0);
   endfunction
`else
   assign seed_load = seed;

   function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] d);
      return d + DATA_W'(1);
   endfunction
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         data_reg       <= '0;
         remaining_reg  <= '0;
         gap_len_reg    <= '0;
         gap_cnt_reg    <= '0;
         beat_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         data_reg       <= data_next;
         remaining_reg  <= remaining_next;
         gap_len_reg    <= gap_len_next;
         gap_cnt_reg    <= gap_cnt_next;
         beat_count_reg <= beat_count_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      data_next       = data_reg;
      remaining_next  = remaining_reg;
      gap_len_next    = gap_len_reg;
      gap_cnt_next    = gap_cnt_reg;
      beat_count_next = beat_count_reg;

      case (state_reg)
         IDLE: begin
            // start is only honoured here; in every other state it is ignored.
            if (start) begin
               data_next      = seed_load;
               remaining_next = burst_len;
               gap_len_next   = gap_len;
               state_next     = (burst_len != '0) ? SEND : FIN;
            end
         end
         SEND: begin
            // Without out_ready nothing changes, so data and last stay stable.
            if (out_ready) begin
               remaining_next  = remaining_reg - LEN_W'(1);
               beat_count_next = beat_count_reg + LEN_W'(1);
               data_next       = advance(data_reg);
               if (remaining_reg == LEN_W'(1)) begin
                  state_next = FIN;
               end else if (gap_len_reg != '0) begin
                  // GAP lasts gap_len cycles: it counts down to zero inclusive.
                  gap_cnt_next = gap_len_reg - GAP_W'(1);
                  state_next   = GAP;
               end
            end
         end
         GAP: begin
            if (gap_cnt_reg == '0) begin
               state_next = SEND;
            end else begin
               gap_cnt_next = gap_cnt_reg - GAP_W'(1);
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign out_valid  = (state_reg == SEND);
   assign out_last   = out_valid && (remaining_reg == LEN_W'(1));
   assign busy       = (state_reg == SEND) || (state_reg == GAP);
   assign done       = (state_reg == FIN);
   assign data_out   = data_reg;
   assign beat_count = beat_count_reg;

endmodule

// File: tb/tb_rv_stream_gen.sv
module tb_rv_stream_gen;

   localparam int DW = 16;
   localparam int LW = 16;
   localparam int GW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] burst_len = '0;
   logic [GW-1:0] gap_len = '0;
   logic [DW-1:0] seed = '0;
   logic          out_ready = 1'b1;
   logic          out_valid;
   logic [DW-1:0] data_out;
   logic          out_last;
   logic          busy;
   logic          done;
   logic [LW-1:0] beat_count;

   rv_stream_gen #(.DATA_W(DW), .LEN_W(LW), .GAP_W(GW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .burst_len  (burst_len),
      .gap_len    (gap_len),
      .seed       (seed),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .data_out   (data_out),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done),
      .beat_count (beat_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   int            checks = 0;
   int            failures = 0;
   beat_t         exp_q[$];
   int            bp_mode = 0;     // 0 always ready, 1 random, 2 stall then ready
   int            stall_left = 0;
   int            cur_gap = 0;
   bit            tracking = 0;
   int            idle_cnt = 0;
   bit            last_pending = 0;
   logic [LW-1:0] model_count = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference sequence rule: +1 with wrap, or the Galois LFSR step.
   function automatic logic [DW-1:0] next_val(input logic [DW-1:0] d);
`ifdef RV_GEN_LFSR_EN
      return (d >> 1) ^ (d[0] ? 16'hB400 : 16'h0000);
`else
      return d + 16'd1;
`endif
   endfunction

   task automatic push_expected(input int len, input logic [DW-1:0] sd);
      logic [DW-1:0] v;
      v = sd;
`ifdef RV_GEN_LFSR_EN
      if (v == '0) v = 16'h0001;
`endif
      for (int i = 0; i < len; i++) begin
         exp_q.push_back('{data: v, last: (i == len - 1)});
         v = next_val(v);
      end
      model_count = model_count + LW'(len);
   endtask

   // Ready driver, changes just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
               out_ready = (stall_left == 0);
               if (stall_left > 0) stall_left--;
            end
         endcase
      end
   end

   // Monitor: compares every presented beat against the scoreboard front.
   // A beat presented with out_ready high transfers on the next rising edge.
   initial begin
      beat_t b;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (last_pending) begin
               check("done_latency", done, 1);
               last_pending = 0;
            end
            if (tracking) begin
               if (out_valid) begin
                  check("gap_cycles", idle_cnt, cur_gap);
                  tracking = 0;
               end else begin
                  idle_cnt++;
               end
            end
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_valid", out_valid, 0);
               end else begin
                  check("beat_data", data_out, exp_q[0].data);
                  check("beat_last", out_last, exp_q[0].last);
                  if (out_ready) begin
                     b = exp_q.pop_front();
                     if (b.last) last_pending = 1;
                     else begin
                        tracking = 1;
                        idle_cnt = 0;
                     end
                  end
               end
            end else begin
               check("last_without_valid", out_last, 0);
            end
         end
      end
   end

   task automatic run_burst(input int len, input int gap, input logic [DW-1:0] sd,
                            input int bp, input int stall, input bit inject);
      bit got;
      bp_mode = bp;
      stall_left = stall;
      cur_gap = gap;
      push_expected(len, sd);
      $display("burst len=%0d gap=%0d seed=%04h bp=%0d inject=%0d", len, gap, sd, bp, inject);
      @(posedge clk); #1;
      start = 1'b1;
      burst_len = LW'(len);
      gap_len = GW'(gap);
      seed = sd;
      @(posedge clk); #1;
      start = 1'b0;
      burst_len = LW'($urandom);
      gap_len = GW'($urandom);
      seed = DW'($urandom);
      @(negedge clk);
      check("first_valid", out_valid, (len != 0));
      check("busy_after_start", busy, (len != 0));
      got = 0;
      for (int c = 0; c < 2000; c++) begin
         if (done) begin
            got = 1;
            break;
         end
         if (inject && len >= 2 && c == 1) begin
            start = 1'b1;
            burst_len = 16'd7;
            gap_len = 8'd0;
            seed = 16'hAAAA;
         end
         if (c == 2) start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      check("done_seen", got, 1);
      check("busy_at_done", busy, 0);
      check("beat_count", beat_count, model_count);
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
      tracking = 0;
      @(negedge clk);
      check("done_one_cycle", done, 0);
   endtask

   task automatic reset_mid_burst();
      bp_mode = 0;
      cur_gap = 0;
      push_expected(4, 16'h0100);
      $display("reset mid-burst len=4 seed=0100");
      @(posedge clk); #1;
      start = 1'b1;
      burst_len = 16'd4;
      gap_len = 8'd0;
      seed = 16'h0100;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_count", beat_count, model_count - 16'd2);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async_valid", out_valid, 0);
      check("rst_async_busy", busy, 0);
      check("rst_async_data", data_out, 0);
      check("rst_async_count", beat_count, 0);
      exp_q.delete();
      tracking = 0;
      last_pending = 0;
      model_count = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_last", out_last, 0);
      check("rst_data", data_out, 0);
      check("rst_count", beat_count, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      run_burst(4, 0, 16'h0001, 0, 0, 0);      // back-to-back beats
      run_burst(2, 0, 16'h1002, 2, 4, 0);      // held under backpressure
      run_burst(3, 2, 16'h0010, 0, 0, 0);      // two idle cycles between beats
      run_burst(3, 0, 16'hFFFE, 0, 0, 0);      // wrap through all-ones
      run_burst(0, 1, 16'h0005, 0, 0, 0);      // empty burst
      run_burst(4, 1, 16'h0200, 1, 0, 1);      // start while busy is ignored
      reset_mid_burst();
      run_burst(2, 0, 16'h3000, 0, 0, 0);      // normal operation after reset
`ifdef RV_GEN_LFSR_EN
      run_burst(3, 0, 16'h0001, 0, 0, 0);
      run_burst(3, 0, 16'h0000, 0, 0, 0);
`endif
      for (int i = 0; i < 25; i++) begin
         int len;
         len = $urandom_range(0, 6);
         run_burst(len, $urandom_range(0, 3), DW'($urandom), $urandom_range(0, 1), 0,
                   (len >= 2) && ($urandom_range(0, 1) == 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
